accelbrot_lane_dispatch: RTL and testbench

//  Fans the single queue->loop enter stream out to NLANES independent accelbrot_loop instances and merges their

---
 rtl/accelbrot_lane_dispatch.sv | 251 +++++++++++++++++++++++++
 tb/tb_accelbrot_lane_dispatch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accelbrot_lane_dispatch.sv
// Fans the queue->loop enter stream out to NLANES loop lanes (packets kept atomic per lane)
// and round-robin merges the per-lane exit streams into one registered exit stream.

module accelbrot_lane_port #(
    parameter int WWIDTH       = 34,
    parameter int TWIDTH       = 24,
    parameter int MAX_INFLIGHT = 64,
    parameter int IFW          = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd,
    input  logic [WWIDTH-1:0] a,
    input  logic [WWIDTH-1:0] b,
    input  logic [TWIDTH-1:0] tag,
    input  logic              start,
    input  logic              inc,
    input  logic              dec,
    input  logic              lane_bp,
    output logic [WWIDTH-1:0] lane_a,
    output logic [WWIDTH-1:0] lane_b,
    output logic [TWIDTH-1:0] lane_tag,
    output logic              lane_start,
    output logic              lane_valid,
    output logic [IFW-1:0]    inflight,
    output logic              eligible
);
    logic dec_ok;

    // never let a stray exit wrap the counter below zero
    assign dec_ok   = dec && (inflight != '0);
    assign eligible = !lane_bp && (inflight < IFW'(MAX_INFLIGHT));

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_a     <= '0;
            lane_b     <= '0;
            lane_tag   <= '0;
            lane_start <= 1'b0;
            lane_valid <= 1'b0;
            inflight   <= '0;
        end else begin
            lane_valid <= fwd;
            lane_start <= fwd && start;
            if (fwd) begin
                lane_a   <= a;
                lane_b   <= b;
                lane_tag <= tag;
            end
            case ({inc, dec_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

module accelbrot_lane_dispatch #(
    parameter int NLANES       = 3,
    parameter int NWORDS       = 8,
    parameter int WWIDTH       = 34,
    parameter int TWIDTH       = 24,
    parameter int CWIDTH       = 20,
    parameter int SEL_MODE     = 0,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WWIDTH-1:0]              enter_a,
    input  logic [WWIDTH-1:0]              enter_b,
    input  logic [TWIDTH-1:0]              enter_tag,
    input  logic                           enter_start,
    input  logic                           enter_valid,
    output logic                           enter_bp,
    output logic [NLANES-1:0][WWIDTH-1:0]  lane_a,
    output logic [NLANES-1:0][WWIDTH-1:0]  lane_b,
    output logic [NLANES-1:0][TWIDTH-1:0]  lane_tag,
    output logic [NLANES-1:0]              lane_start,
    output logic [NLANES-1:0]              lane_valid,
    input  logic [NLANES-1:0]              lane_bp,
    input  logic [NLANES-1:0][TWIDTH-1:0]  lane_exit_tag,
    input  logic [NLANES-1:0][CWIDTH-1:0]  lane_exit_count,
    input  logic [NLANES-1:0]              lane_exit_valid,
    output logic [NLANES-1:0]              lane_exit_ready,
    output logic [TWIDTH-1:0]              exit_tag,
    output logic [CWIDTH-1:0]              exit_count,
    output logic                           exit_valid,
    input  logic                           exit_ready,
    output logic [31:0]                    sts_num_dispatched,
    output logic [31:0]                    sts_num_merged,
    output logic                           sts_proto_err
);
    localparam int LW  = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int BW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int IFW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [BW-1:0] LAST = BW'(NWORDS - 1);

    typedef enum logic {IDLE, FWD} state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [LW-1:0]                sel_q, sel_d, pick, fwd_lane, rr_ptr, mrg_ptr, gnt;
    logic                         accept, fwd_beat, proto, any_elig, found, gfound, load_allowed;
    logic [NLANES-1:0]            elig, fwd_vec, inc_vec;
    logic [NLANES-1:0][IFW-1:0]   inflight;
    logic [IFW-1:0]               min_cnt;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        accelbrot_lane_port #(
            .WWIDTH(WWIDTH), .TWIDTH(TWIDTH), .MAX_INFLIGHT(MAX_INFLIGHT), .IFW(IFW)
        ) u_port (
            .clk(clk), .rst(rst), .fwd(fwd_vec[i]),
            .a(enter_a), .b(enter_b), .tag(enter_tag), .start(enter_start),
            .inc(inc_vec[i]), .dec(lane_exit_ready[i]), .lane_bp(lane_bp[i]),
            .lane_a(lane_a[i]), .lane_b(lane_b[i]), .lane_tag(lane_tag[i]),
            .lane_start(lane_start[i]), .lane_valid(lane_valid[i]),
            .inflight(inflight[i]), .eligible(elig[i])
        );
    end

    // lane selection: round-robin from rr_ptr, or least-in-flight with lowest-index tie-break
    always_comb begin
        pick    = '0;
        found   = 1'b0;
        min_cnt = '1;
        if (SEL_MODE == 0) begin
            for (int k = 0; k < NLANES; k++) begin
                int idx;
                idx = (int'(rr_ptr) + k) % NLANES;
                if (!found && elig[idx]) begin
                    pick  = LW'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NLANES; i++) begin
                if (elig[i] && (!found || inflight[i] < min_cnt)) begin
                    pick    = LW'(i);
                    min_cnt = inflight[i];
                    found   = 1'b1;
                end
            end
        end
    end

    assign any_elig = |elig;
    assign enter_bp = (state_q == IDLE) ? !any_elig : (beat_q != LAST);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        sel_d    = sel_q;
        accept   = 1'b0;
        fwd_beat = 1'b0;
        fwd_lane = sel_q;
        proto    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enter_valid && enter_start) begin
                    if (!enter_bp) begin
                        accept   = 1'b1;
                        fwd_beat = 1'b1;
                        fwd_lane = pick;
                        sel_d    = pick;
                        if (NWORDS > 1) begin
                            state_d = FWD;
                            beat_d  = BW'(1);
                        end
                    end else begin
                        proto = 1'b1;
                    end
                end
            end
            FWD: begin
                if (enter_valid) begin
                    if (enter_start) begin
                        proto = 1'b1;
                    end else begin
                        fwd_beat = 1'b1;
                        if (beat_q == LAST) begin
                            state_d = IDLE;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fwd_vec = '0;
        inc_vec = '0;
        if (fwd_beat) fwd_vec[fwd_lane] = 1'b1;
        if (accept)   inc_vec[pick]     = 1'b1;
    end

    // merge grant: first valid lane at or after mrg_ptr
    always_comb begin
        gnt             = '0;
        gfound          = 1'b0;
        lane_exit_ready = '0;
        load_allowed    = !exit_valid || exit_ready;
        for (int k = 0; k < NLANES; k++) begin
            int idx;
            idx = (int'(mrg_ptr) + k) % NLANES;
            if (!gfound && lane_exit_valid[idx]) begin
                gnt    = LW'(idx);
                gfound = 1'b1;
            end
        end
        if (load_allowed && gfound) lane_exit_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            beat_q             <= '0;
            sel_q              <= '0;
            rr_ptr             <= '0;
            mrg_ptr            <= '0;
            exit_tag           <= '0;
            exit_count         <= '0;
            exit_valid         <= 1'b0;
            sts_num_dispatched <= '0;
            sts_num_merged     <= '0;
            sts_proto_err      <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            sel_q   <= sel_d;
            if (accept) begin
                rr_ptr             <= (pick == LW'(NLANES - 1)) ? '0 : pick + 1'b1;
                sts_num_dispatched <= sts_num_dispatched + 32'd1;
            end
            if (proto) sts_proto_err <= 1'b1;
            if (exit_valid && exit_ready) sts_num_merged <= sts_num_merged + 32'd1;
            if (load_allowed) begin
                exit_valid <= gfound;
                if (gfound) begin
                    exit_tag   <= lane_exit_tag[gnt];
                    exit_count <= lane_exit_count[gnt];
                    mrg_ptr    <= (gnt == LW'(NLANES - 1)) ? '0 : gnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_accelbrot_lane_dispatch.sv
// Directed bench: u0 is round-robin (cap 64), u1 is least-in-flight (cap 2); both share inputs.

module tb_accelbrot_lane_dispatch;
    logic              clk = 1'b0;
    logic              rst;
    logic [33:0]       enter_a, enter_b;
    logic [23:0]       enter_tag;
    logic              enter_start, enter_valid;
    logic [2:0]        lane_bp;
    logic [2:0][23:0]  lane_exit_tag;
    logic [2:0][19:0]  lane_exit_count;
    logic [2:0]        lane_exit_valid;
    logic              exit_ready;

    logic              u0_enter_bp, u1_enter_bp;
    logic [2:0][33:0]  u0_lane_a, u0_lane_b, u1_lane_a, u1_lane_b;
    logic [2:0][23:0]  u0_lane_tag, u1_lane_tag;
    logic [2:0]        u0_lane_start, u0_lane_valid, u1_lane_start, u1_lane_valid;
    logic [2:0]        u0_lane_exit_ready, u1_lane_exit_ready;
    logic [23:0]       u0_exit_tag, u1_exit_tag;
    logic [19:0]       u0_exit_count, u1_exit_count;
    logic              u0_exit_valid, u1_exit_valid;
    logic [31:0]       u0_disp, u0_merg, u1_disp, u1_merg;
    logic              u0_perr, u1_perr;

    int n_cmp = 0;
    int n_err = 0;
    logic       bp0_at_start, bp1_at_start;
    logic [2:0] lv0, lv1;

    always #5 clk = ~clk;

    accelbrot_lane_dispatch #(.SEL_MODE(0), .MAX_INFLIGHT(64)) u0 (
        .clk(clk), .rst(rst), .enter_a(enter_a), .enter_b(enter_b), .enter_tag(enter_tag),
        .enter_start(enter_start), .enter_valid(enter_valid), .enter_bp(u0_enter_bp),
        .lane_a(u0_lane_a), .lane_b(u0_lane_b), .lane_tag(u0_lane_tag),
        .lane_start(u0_lane_start), .lane_valid(u0_lane_valid), .lane_bp(lane_bp),
        .lane_exit_tag(lane_exit_tag), .lane_exit_count(lane_exit_count),
        .lane_exit_valid(lane_exit_valid), .lane_exit_ready(u0_lane_exit_ready),
        .exit_tag(u0_exit_tag), .exit_count(u0_exit_count), .exit_valid(u0_exit_valid),
        .exit_ready(exit_ready), .sts_num_dispatched(u0_disp), .sts_num_merged(u0_merg),
        .sts_proto_err(u0_perr)
    );

    accelbrot_lane_dispatch #(.SEL_MODE(1), .MAX_INFLIGHT(2)) u1 (
        .clk(clk), .rst(rst), .enter_a(enter_a), .enter_b(enter_b), .enter_tag(enter_tag),
        .enter_start(enter_start), .enter_valid(enter_valid), .enter_bp(u1_enter_bp),
        .lane_a(u1_lane_a), .lane_b(u1_lane_b), .lane_tag(u1_lane_tag),
        .lane_start(u1_lane_start), .lane_valid(u1_lane_valid), .lane_bp(lane_bp),
        .lane_exit_tag(lane_exit_tag), .lane_exit_count(lane_exit_count),
        .lane_exit_valid(lane_exit_valid), .lane_exit_ready(u1_lane_exit_ready),
        .exit_tag(u1_exit_tag), .exit_count(u1_exit_count), .exit_valid(u1_exit_valid),
        .exit_ready(exit_ready), .sts_num_dispatched(u1_disp), .sts_num_merged(u1_merg),
        .sts_proto_err(u1_perr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [23:0] tag, input int k);
        enter_valid = 1'b1;
        enter_start = (k == 0);
        enter_tag   = tag;
        enter_a     = 34'(tag * 16 + k);
        enter_b     = 34'(tag * 256 + k);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        enter_valid     = 1'b0;
        enter_start     = 1'b0;
        lane_bp         = 3'b000;
        lane_exit_valid = 3'b000;
        exit_ready      = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // one 8-beat packet, recording backpressure at the start beat and the lane it landed on
    task automatic send_pkt(input logic [23:0] tag);
        for (int k = 0; k < 8; k++) begin
            drive_beat(tag, k);
            #1;
            if (k == 0) begin
                bp0_at_start = u0_enter_bp;
                bp1_at_start = u1_enter_bp;
            end
            step();
            if (k == 0) begin
                lv0 = u0_lane_valid;
                lv1 = u1_lane_valid;
            end
        end
        enter_valid = 1'b0;
        enter_start = 1'b0;
    endtask

    initial begin
        enter_a = '0; enter_b = '0; enter_tag = '0;
        lane_exit_tag = '0; lane_exit_count = '0;
        @(negedge clk);
        do_reset();

        chk("rst_lane_valid", u0_lane_valid, 3'b000);
        chk("rst_exit_valid", u0_exit_valid, 1'b0);
        chk("rst_dispatched", u0_disp, 32'd0);
        chk("rst_proto_err", u0_perr, 1'b0);
        chk("rst_enter_bp", u0_enter_bp, 1'b0);
        chk("rst_exit_ready", u0_lane_exit_ready, 3'b000);

        // round-robin, back-to-back packets
        for (int p = 0; p < 6; p++) begin
            send_pkt(24'(p + 1));
            chk("rr_bp_at_start", bp0_at_start, 1'b0);
            chk("rr_lane", lv0, 64'(3'b001 << (p % 3)));
        end
        chk("rr_dispatched", u0_disp, 32'd6);

        // only lane 2 eligible
        do_reset();
        lane_bp = 3'b011;
        for (int k = 0; k < 8; k++) begin
            drive_beat(24'h0A5, k);
            step();
            chk("bp_lane_valid", u0_lane_valid, 3'b100);
            chk("bp_lane_a", u0_lane_a[2], 64'(24'h0A5 * 16 + k));
            if (k == 0) begin
                chk("bp_lane_tag", u0_lane_tag[2], 24'h0A5);
                chk("bp_lane_start", u0_lane_start, 3'b100);
            end
        end
        enter_valid = 1'b0;
        step();
        chk("bp_idle_valid", u0_lane_valid, 3'b000);

        // all lanes backpressured: start is a protocol error
        do_reset();
        lane_bp = 3'b111;
        #1;
        chk("allbp_enter_bp", u0_enter_bp, 1'b1);
        drive_beat(24'h011, 0);
        step();
        enter_valid = 1'b0;
        chk("allbp_no_valid", u0_lane_valid, 3'b000);
        chk("allbp_proto_err", u0_perr, 1'b1);
        chk("allbp_dispatched", u0_disp, 32'd0);

        // least-in-flight with cap 2
        do_reset();
        for (int p = 0; p < 6; p++) begin
            send_pkt(24'(8'h40 + p));
            chk("lif_lane", lv1, 64'(3'b001 << (p % 3)));
        end
        #1;
        chk("lif_full_bp", u1_enter_bp, 1'b1);
        lane_exit_tag[1]   = 24'h000077;
        lane_exit_count[1] = 20'd5;
        lane_exit_valid    = 3'b010;
        exit_ready         = 1'b1;
        #1;
        chk("lif_exit_ready", u1_lane_exit_ready, 3'b010);
        step();
        lane_exit_valid = 3'b000;
        #1;
        chk("lif_exit_valid", u1_exit_valid, 1'b1);
        chk("lif_exit_tag", u1_exit_tag, 24'h000077);
        chk("lif_bp_freed", u1_enter_bp, 1'b0);
        send_pkt(24'h47);
        chk("lif_7th_lane", lv1, 3'b010);
        chk("lif_7th_bp", bp1_at_start, 1'b0);

        // merge order with stalls
        do_reset();
        for (int i = 0; i < 3; i++) begin
            lane_exit_tag[i]   = 24'(12'h100 + i);
            lane_exit_count[i] = 20'(12'h200 + i);
        end
        lane_exit_valid = 3'b111;
        exit_ready      = 1'b1;
        #1;
        chk("mrg_ready0", u0_lane_exit_ready, 3'b001);
        step();
        exit_ready = 1'b0;
        chk("mrg_tag0", u0_exit_tag, 24'h100);
        step();
        chk("mrg_stall_tag0", u0_exit_tag, 24'h100);
        chk("mrg_stall_cnt0", u0_exit_count, 20'h200);
        chk("mrg_stall_ready", u0_lane_exit_ready, 3'b000);
        exit_ready = 1'b1;
        #1;
        chk("mrg_ready1", u0_lane_exit_ready, 3'b010);
        step();
        exit_ready = 1'b0;
        chk("mrg_tag1", u0_exit_tag, 24'h101);
        chk("mrg_merged1", u0_merg, 32'd1);
        step();
        chk("mrg_stall_tag1", u0_exit_tag, 24'h101);
        exit_ready = 1'b1;
        step();
        exit_ready = 1'b0;
        chk("mrg_tag2", u0_exit_tag, 24'h102);
        chk("mrg_cnt2", u0_exit_count, 20'h202);
        step();
        exit_ready = 1'b1;
        step();
        chk("mrg_tag_wrap", u0_exit_tag, 24'h100);
        chk("mrg_merged3", u0_merg, 32'd3);
        lane_exit_valid = 3'b000;
        exit_ready = 1'b0;

        // reset in the middle of a packet
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_beat(24'h0C3, k);
            step();
        end
        drive_beat(24'h0C3, 3);
        rst = 1'b1;
        step();
        chk("midrst_lane_valid", u0_lane_valid, 3'b000);
        chk("midrst_lane_a_zero", (u0_lane_a == '0), 1'b1);
        chk("midrst_dispatched", u0_disp, 32'd0);
        chk("midrst_exit_valid", u0_exit_valid, 1'b0);
        rst = 1'b0;
        enter_valid = 1'b0;
        step();
        send_pkt(24'h033);
        chk("midrst_next_lane", lv0, 3'b001);
        chk("midrst_next_disp", u0_disp, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
